// File: rtl/subtractor_12b_pipe_pkg.sv
// Shared widths and the per-stage pipeline record for the pipelined 12-bit subtractor.
package sub12_pkg;

    localparam int WIDTH_DEF   = 12;
    localparam int SLICE_W_DEF = 3;

    typedef struct packed {
        logic                 valid;
        logic                 borrow;
        logic [WIDTH_DEF-1:0] x_rem;
        logic [WIDTH_DEF-1:0] y_rem;
        logic [WIDTH_DEF-1:0] d_acc;
    } stage_t;

endpackage

// File: rtl/subtractor_12b_pipe_if.sv
// Valid/ready operand and result bundle for subtractor_12b_pipe.
// Ovf is present only when SUB12_OVF_EN is defined.
interface subtractor_12b_pipe_if #(parameter int WIDTH = sub12_pkg::WIDTH_DEF);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bo;
`ifdef SUB12_OVF_EN
    logic             Ovf;
`endif

    modport master (
        output in_valid, X, Y, Bin, out_ready,
`ifdef SUB12_OVF_EN
        input  Ovf,
`endif
        input  in_ready, out_valid, D, Bo
    );

    modport slave (
        input  in_valid, X, Y, Bin, out_ready,
`ifdef SUB12_OVF_EN
        output Ovf,
`endif
        output in_ready, out_valid, D, Bo
    );

endinterface

// File: rtl/subtractor_12b_pipe_slice.sv
// sub_slice_3b: combinational borrow-lookahead subtract of one slice, d = a - b - bin.
module sub_slice_3b
    import sub12_pkg::*;
#(
    parameter int W = SLICE_W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic [W-1:0] d_o,
    output logic         bout_o,
    output logic         bmsb_o
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = ~a_i & b_i;
    assign p = ~(a_i ^ b_i);

    // Each borrow is a flat sum of generate terms gated by the propagates above them.
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = bin_i;
        for (int i = 0; i < W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & bin_i);
        end
    end

    assign d_o    = a_i ^ b_i ^ c[W-1:0];
    assign bout_o = c[W];
    assign bmsb_o = c[W-1];

endmodule

// File: rtl/subtractor_12b_pipe.sv
// Pipelined 12-bit subtractor D = X - Y - Bin, one slice resolved per stage, full backpressure.
// Define SUB12_OVF_EN to add the pipelined signed-overflow output Ovf.
module subtractor_12b_pipe
    import sub12_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    subtractor_12b_pipe_if.slave  bus_io
);

    localparam int NSTG = WIDTH / SLICE_W;

    stage_t             stg_q [NSTG-1];
    stage_t             stg_d [NSTG-1];
    stage_t             sin   [NSTG];
    logic [SLICE_W-1:0] slice_d    [NSTG];
    logic               slice_bo   [NSTG];
    logic               slice_bmsb [NSTG];

    logic               out_valid_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   d_d;
    logic               bo_q;
    logic               en;

    assign en = !out_valid_q || bus_io.out_ready;

    // Stage 0 reads the live operands; later stages read the previous stage register.
    always_comb begin
        sin[0].valid  = bus_io.in_valid;
        sin[0].borrow = bus_io.Bin;
        sin[0].x_rem  = bus_io.X;
        sin[0].y_rem  = bus_io.Y;
        sin[0].d_acc  = '0;
        for (int s = 1; s < NSTG; s++) begin
            sin[s] = stg_q[s-1];
        end
    end

    genvar gs;
    generate
        for (gs = 0; gs < NSTG; gs++) begin : g_slice
            sub_slice_3b #(.W(SLICE_W)) u_slice (
                .a_i    (sin[gs].x_rem[gs*SLICE_W +: SLICE_W]),
                .b_i    (sin[gs].y_rem[gs*SLICE_W +: SLICE_W]),
                .bin_i  (sin[gs].borrow),
                .d_o    (slice_d[gs]),
                .bout_o (slice_bo[gs]),
                .bmsb_o (slice_bmsb[gs])
            );
        end
    endgenerate

    always_comb begin
        for (int s = 0; s < NSTG - 1; s++) begin
            stg_d[s]                               = sin[s];
            stg_d[s].borrow                        = slice_bo[s];
            stg_d[s].d_acc[s*SLICE_W +: SLICE_W]   = slice_d[s];
        end
        d_d                                        = sin[NSTG-1].d_acc;
        d_d[(NSTG-1)*SLICE_W +: SLICE_W]           = slice_d[NSTG-1];
    end

`ifdef SUB12_OVF_EN
    logic ovf_q;
    assign bus_io.Ovf = ovf_q;
`endif

    // The final stage doubles as the output register; it only loads on valid slots so results hold through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSTG - 1; s++) begin
                stg_q[s] <= '0;
            end
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bo_q        <= 1'b0;
`ifdef SUB12_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else if (en) begin
            stg_q       <= stg_d;
            out_valid_q <= sin[NSTG-1].valid;
            if (sin[NSTG-1].valid) begin
                d_q  <= d_d;
                bo_q <= slice_bo[NSTG-1];
`ifdef SUB12_OVF_EN
                ovf_q <= slice_bmsb[NSTG-1] ^ slice_bo[NSTG-1];
`endif
            end
        end
    end

    logic unused_bmsb;
    always_comb begin
        unused_bmsb = 1'b0;
        for (int s = 0; s < NSTG; s++) begin
            unused_bmsb = unused_bmsb ^ slice_bmsb[s];
        end
    end

    assign bus_io.in_ready  = en;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.D         = d_q;
    assign bus_io.Bo        = bo_q;

endmodule

// File: tb/tb_subtractor_12b_pipe.sv
// Self-checking bench for subtractor_12b_pipe: scoreboard of reference results, directed and random streams.
// Ovf is checked only when built with SUB12_OVF_EN.
module tb_subtractor_12b_pipe;
    import sub12_pkg::*;

    typedef struct {
        logic [11:0] d;
        logic        bo;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   inCount = 0;
    int   outCount = 0;
    exp_t sbQ [$];

    always #5 clk = ~clk;

    subtractor_12b_pipe_if bus ();

    subtractor_12b_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    function automatic exp_t model(input logic [11:0] x, input logic [11:0] y, input logic b);
        exp_t        e;
        logic [12:0] full;
        int          s;
        full  = {1'b0, x} - {1'b0, y} - {12'd0, b};
        s     = int'($signed(x)) - int'($signed(y)) - (b ? 1 : 0);
        e.d   = full[11:0];
        e.bo  = full[12];
        e.ovf = (s > 2047) || (s < -2048);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [11:0] x, input logic [11:0] y,
                                 input logic b, input logic ordy);
        bus.in_valid  = v;
        bus.X         = x;
        bus.Y         = y;
        bus.Bin       = b;
        bus.out_ready = ordy;
    endtask

    // Scores the transfers that happen at the coming rising edge, then advances to the next falling edge.
    task automatic checkOutput(output logic accepted);
        exp_t e;
        #1;
        accepted = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            outCount++;
            if (sbQ.size() == 0) begin
                chk("sb_unexpected_out", 32'(sbQ.size()), 32'd1);
            end else begin
                e = sbQ.pop_front();
                chk("sb_D", 32'(bus.D), 32'(e.d));
                chk("sb_Bo", 32'(bus.Bo), 32'(e.bo));
`ifdef SUB12_OVF_EN
                chk("sb_Ovf", 32'(bus.Ovf), 32'(e.ovf));
`endif
            end
        end
        if (accepted) begin
            inCount++;
            sbQ.push_back(model(bus.X, bus.Y, bus.Bin));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while ((sbQ.size() != 0 || bus.out_valid) && n < 40) begin
            applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
            checkOutput(acc);
            n++;
        end
        chk("drain_left", 32'(sbQ.size()), 32'd0);
    endtask

    task automatic latencyCheck(input logic [11:0] x, input logic [11:0] y, input logic b);
        exp_t e;
        logic acc;
        e = model(x, y, b);
        applyStimulus(1'b1, x, y, b, 1'b1);
        checkOutput(acc);
        chk("lat_accept", 32'(acc), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
            #1;
            chk("lat_early", 32'(bus.out_valid), 32'd0);
            checkOutput(acc);
        end
        #1;
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_D", 32'(bus.D), 32'(e.d));
        chk("lat_Bo", 32'(bus.Bo), 32'(e.bo));
        checkOutput(acc);
        #1;
        chk("lat_alone", 32'(bus.out_valid), 32'd0);
    endtask

    logic [11:0] dirX [12] = '{12'h000, 12'h000, 12'h000, 12'hFFF, 12'h800, 12'h7FF,
                               12'h100, 12'hABC, 12'h123, 12'hFFF, 12'h555, 12'h800};
    logic [11:0] dirY [12] = '{12'h001, 12'h000, 12'hFFF, 12'hFFF, 12'h001, 12'hFFF,
                               12'h001, 12'h0BC, 12'h321, 12'h000, 12'hAAA, 12'h7FF};
    logic        dirB [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        logic        acc;
        logic        stall;
        logic [11:0] dHeld;
        int          idx;
        int          base;
        int          cyc;

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_D", 32'(bus.D), 32'd0);
        chk("rst_Bo", 32'(bus.Bo), 32'd0);
`ifdef SUB12_OVF_EN
        chk("rst_Ovf", 32'(bus.Ovf), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Single op, exact latency
        latencyCheck(12'h005, 12'h003, 1'b0);

        // Directed boundary stream, back to back
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, dirX[i], dirY[i], dirB[i], 1'b1);
            checkOutput(acc);
        end
        drain();

        // Eight back-to-back ops with out_ready low on cycles 5-7
        base = outCount;
        idx  = 0;
        cyc  = 0;
        dHeld = '0;
        while ((idx < 8 || sbQ.size() != 0 || bus.out_valid) && cyc < 40) begin
            stall = (cyc >= 4) && (cyc <= 6);
            applyStimulus(idx < 8, 12'(12'h321 + idx * 12'h111), 12'(12'h010 * idx), idx[0], !stall);
            #1;
            if (cyc == 4) dHeld = bus.D;
            if (stall) begin
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            end
            if (cyc == 5 || cyc == 6) chk("stall_D_stable", 32'(bus.D), 32'(dHeld));
            checkOutput(acc);
            if (acc) idx++;
            cyc++;
        end
        chk("stall_count", 32'(outCount - base), 32'd8);
        chk("stall_queue", 32'(sbQ.size()), 32'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 12'h0F0 + 12'(i), 12'h00F, 1'b0, 1'b1);
            checkOutput(acc);
        end
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_D", 32'(bus.D), 32'd0);
        chk("midrst_Bo", 32'(bus.Bo), 32'd0);
        sbQ.delete();
        inCount  = 0;
        outCount = 0;
        applyStimulus(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        latencyCheck(12'h000, 12'h000, 1'b1);

        // Random traffic with random backpressure
        idx = 0;
        cyc = 0;
        while (idx < 10000 && cyc < 60000) begin
            applyStimulus($urandom_range(0, 3) != 0, 12'($urandom_range(0, 4095)),
                          12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
            checkOutput(acc);
            if (acc) idx++;
            cyc++;
        end
        chk("rand_accepted", 32'(idx), 32'd10000);
        drain();
        chk("total_inout", 32'(outCount), 32'(inCount));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
